// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl - MEM-stage data-memory access controller (LC-3b).
// Converts level-held load/store requests from the MEM stage into exactly one
// registered data-cache transaction each, returns a one-cycle completion pulse
// with registered read data, and stalls the MEM stage while access is pending.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_read/req_write  MEM-stage load/store request (level, held while stalled)
//   req_addr/req_wdata  access address / store data
//   req_byte_en         store byte enables
//   pipe_advance        MEM pipeline register loads this cycle
//   req_restart         current instruction needs another access (LDI/STI)
//   cache_resp/_rdata   data-cache completion and read data
//   mem_read/mem_write  registered cache strobes
//   mem_address/_wdata  captured address / store data
//   mem_byte_enable     captured enables (2'b11 for reads)
//   mem_resp            one-cycle completion pulse
//   mem_rdata           last completed read data, held
//   mem_stall           stall MEM stage and upstream (combinational)
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_byte_en,
  input  logic        pipe_advance,
  input  logic        req_restart,
  input  logic        cache_resp,
  input  logic [15:0] cache_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        mem_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      mem_resp        <= 1'b0;
      mem_rdata       <= '0;
    end else begin
      mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (req_read | req_write) begin
            mem_address     <= req_addr;
            mem_wdata       <= req_wdata;
            // A simultaneous read+write is issued as the write alone.
            mem_write       <= req_write;
            mem_read        <= ~req_write;
            mem_byte_enable <= req_write ? req_byte_en : 2'b11;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (cache_resp) begin
            if (mem_read) begin
              mem_rdata <= cache_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_resp  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Held requests are ignored here so they are never reissued.
          if (pipe_advance | req_restart) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:    mem_stall = req_read | req_write;
      BUSY:    mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: directed test-plan sequences followed by
// randomized transactions checked against a transaction-level model.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_read, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_byte_en;
  logic        pipe_advance, req_restart;
  logic        cache_resp;
  logic [15:0] cache_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        mem_stall;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: last completed read data.
  logic [15:0] exp_rdata;

  dmem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
    .pipe_advance(pipe_advance), .req_restart(req_restart),
    .cache_resp(cache_resp), .cache_rdata(cache_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE and run it to the first DONE cycle.
  // lat = number of BUSY cycles (cache_resp driven in the last one).
  // Request inputs are left asserted on return.
  task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be,
                       input int unsigned lat, input logic [15:0] rdata);
    logic        e_wr, e_rd;
    logic [1:0]  e_be;
    e_wr = wr;
    e_rd = rd & ~wr;
    e_be = wr ? be : 2'b11;
    req_read = rd; req_write = wr;
    req_addr = addr; req_wdata = wdata; req_byte_en = be;
    #1;
    chk("idle_stall", {15'b0, mem_stall}, 16'd1);
    chk("idle_resp", {15'b0, mem_resp}, 16'd0);
    step();
    for (int unsigned i = 0; i < lat; i++) begin
      chk("busy_read", {15'b0, mem_read}, {15'b0, e_rd});
      chk("busy_write", {15'b0, mem_write}, {15'b0, e_wr});
      chk("busy_addr", mem_address, addr);
      chk("busy_wdata", mem_wdata, wdata);
      chk("busy_be", {14'b0, mem_byte_enable}, {14'b0, e_be});
      chk("busy_stall", {15'b0, mem_stall}, 16'd1);
      chk("busy_resp", {15'b0, mem_resp}, 16'd0);
      chk("busy_rdata", mem_rdata, exp_rdata);
      if (i == 0) begin
        req_addr = ~addr; req_wdata = ~wdata; req_byte_en = ~be;
      end
      if (i == lat - 1) begin
        cache_resp = 1'b1; cache_rdata = rdata;
      end else begin
        cache_rdata = $urandom();
      end
      step();
      cache_resp = 1'b0;
      cache_rdata = $urandom();
    end
    if (e_rd) exp_rdata = rdata;
    chk("done_resp", {15'b0, mem_resp}, 16'd1);
    chk("done_read", {15'b0, mem_read}, 16'd0);
    chk("done_write", {15'b0, mem_write}, 16'd0);
    chk("done_stall", {15'b0, mem_stall}, 16'd0);
    chk("done_rdata", mem_rdata, exp_rdata);
  endtask

  task automatic advance();
    req_read = 1'b0; req_write = 1'b0; pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0;
    chk("adv_stall", {15'b0, mem_stall}, 16'd0);
    chk("adv_resp", {15'b0, mem_resp}, 16'd0);
    chk("adv_strobe", {14'b0, mem_read, mem_write}, 16'd0);
  endtask

  task automatic restart();
    req_restart = 1'b1;
    step();
    req_restart = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_byte_en = 0;
    pipe_advance = 0; req_restart = 0; cache_resp = 0; cache_rdata = 0;
    exp_rdata = '0;
    #3;
    chk("rst_strobe", {14'b0, mem_read, mem_write}, 16'd0);
    chk("rst_addr", mem_address, 16'h0);
    chk("rst_wdata", mem_wdata, 16'h0);
    chk("rst_be", {14'b0, mem_byte_enable}, 16'd0);
    chk("rst_resp", {15'b0, mem_resp}, 16'd0);
    chk("rst_rdata", mem_rdata, 16'h0);
    chk("rst_stall", {15'b0, mem_stall}, 16'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single load followed by a held request with no advance.
    issue(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 3, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_read", {15'b0, mem_read}, 16'd0);
      chk("held_resp", {15'b0, mem_resp}, 16'd0);
      chk("held_stall", {15'b0, mem_stall}, 16'd0);
      chk("held_rdata", mem_rdata, 16'hBEEF);
    end
    advance();

    // LDI: read pointer, restart, read through it.
    issue(1'b1, 1'b0, 16'h0100, 16'h0, 2'b00, 1, 16'h0200);
    req_addr = 16'h0200;
    restart();
    issue(1'b1, 1'b0, 16'h0200, 16'h0, 2'b00, 2, 16'h00AA);
    chk("ldi_final", mem_rdata, 16'h00AA);
    advance();

    // STI: read pointer, restart, write through it.
    issue(1'b1, 1'b0, 16'h0300, 16'h0, 2'b00, 2, 16'h0400);
    restart();
    issue(1'b0, 1'b1, 16'h0400, 16'h5555, 2'b11, 2, 16'hDEAD);
    chk("sti_rdata", mem_rdata, 16'h0400);
    advance();

    // Read+write together with partial enables; inputs perturbed mid-BUSY.
    issue(1'b1, 1'b1, 16'h0A0A, 16'h1357, 2'b01, 3, 16'hF00D);
    chk("both_rdata", mem_rdata, 16'h0400);
    advance();

    // Randomized transactions, mixing advance and restart endings.
    for (int n = 0; n < 40; n++) begin
      logic rd, wr;
      int unsigned k;
      k  = $urandom_range(1, 3);
      rd = k[0];
      wr = k[1];
      issue(rd, wr, 16'($urandom()), 16'($urandom()), 2'($urandom()),
            $urandom_range(1, 4), 16'($urandom()));
      if ($urandom_range(0, 1) == 1) begin
        restart();
      end else begin
        advance();
        if ($urandom_range(0, 1) == 1) begin
          step();
          chk("gap_stall", {15'b0, mem_stall}, 16'd0);
        end
      end
    end
    advance();

    // Reset in the middle of BUSY.
    req_read = 1'b1; req_addr = 16'h0ABC;
    step();
    step();
    chk("pre_rst_read", {15'b0, mem_read}, 16'd1);
    #2;
    rst_n = 1'b0;
    exp_rdata = '0;
    #1;
    chk("mid_rst_read", {15'b0, mem_read}, 16'd0);
    chk("mid_rst_addr", mem_address, 16'h0);
    chk("mid_rst_rdata", mem_rdata, 16'h0);
    chk("mid_rst_resp", {15'b0, mem_resp}, 16'd0);
    req_read = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    cache_resp = 1'b1; cache_rdata = 16'h7777;
    step();
    cache_resp = 1'b0;
    chk("post_rst_resp", {15'b0, mem_resp}, 16'd0);
    chk("post_rst_rdata", mem_rdata, 16'h0);
    chk("post_rst_stall", {15'b0, mem_stall}, 16'd0);
    step();
    chk("post_rst_resp2", {15'b0, mem_resp}, 16'd0);
    // Controller must be back in IDLE and accept a new request.
    issue(1'b1, 1'b0, 16'h4242, 16'h0, 2'b00, 1, 16'h1111);
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
